pbit_state_histogram: RTL and testbench

//   Synthesizable on-chip sampler/histogrammer for a p-bit network output word.

---
 rtl/pbit_state_histogram.sv | 143 ++++++++++++++
 tb/tb_pbit_state_histogram.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pbit_state_histogram.sv
// On-chip state histogrammer for a p-bit network: samples the output word every
// SAMPLE_DIV clocks and bumps one saturating counter per observed state.
module pbit_state_histogram #(
  parameter int NBITS      = 5,
  parameter int SAMPLE_DIV = 15,
  parameter int CNT_W      = 16,
  parameter bit REVERSE    = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      sample_target,
  input  logic [NBITS-1:0] state_in,
  input  logic             rd_en,
  input  logic [NBITS-1:0] rd_addr,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic [31:0]      total_samples,
  output logic             sat_flag,
  output logic [1:0]       o_dbg_state
);

  localparam int NBINS = 1 << NBITS;
  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_busy;
  logic               r_done;
  logic [DIV_W-1:0]   r_div;
  logic               r_pend;
  logic [NBITS-1:0]   r_sample;
  logic [31:0]        r_total;
  logic               r_sat;
  logic [CNT_W-1:0]   r_bins [NBINS];
  logic [CNT_W-1:0]   r_rd_data;
  logic               r_rd_valid;

  logic               w_tick;
  logic               w_commit;
  logic [31:0]        w_total_inc;
  logic               w_hit_target;
  logic [NBITS-1:0]   w_rev;
  logic [NBITS-1:0]   w_sample_idx;

  for (genvar g = 0; g < NBITS; g++) begin : g_rev
    assign w_rev[g] = state_in[NBITS-1-g];
  end
  assign w_sample_idx = REVERSE ? w_rev : state_in;

  // A tick is suppressed by stop in the same cycle so no new sample follows a stop;
  // start discards both a pending tick and a not-yet-committed sample.
  assign w_tick       = (r_state == S_RUN) && (r_div == DIV_LAST) && !start && !stop;
  assign w_commit     = r_pend && !start;
  assign w_total_inc  = (r_total == 32'hFFFF_FFFF) ? r_total : r_total + 32'd1;
  assign w_hit_target = w_commit && (sample_target != 32'd0) && (w_total_inc == sample_target);

  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = S_RUN;
    end else if (r_state == S_RUN && (stop || w_hit_target)) begin
      w_next = S_DONE;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_div    <= '0;
      r_pend   <= 1'b0;
      r_sample <= '0;
      r_total  <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_RUN);
      r_done  <= (w_next == S_DONE);
      if (start) begin
        r_div   <= '0;
        r_pend  <= 1'b0;
        r_total <= '0;
      end else begin
        if (r_state == S_RUN) begin
          r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
        end
        r_pend <= w_tick;
        if (w_tick) begin
          r_sample <= w_sample_idx;
        end
        if (w_commit) begin
          r_total <= w_total_inc;
        end
      end
    end
  end

  // sat_flag records an increment that was refused because the bin was full.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NBINS; i++) r_bins[i] <= '0;
      r_sat <= 1'b0;
    end else if (start) begin
      for (int i = 0; i < NBINS; i++) r_bins[i] <= '0;
      r_sat <= 1'b0;
    end else if (w_commit) begin
      if (r_bins[r_sample] == CNT_MAX) begin
        r_sat <= 1'b1;
      end else begin
        r_bins[r_sample] <= r_bins[r_sample] + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en && (r_state != S_RUN);
      if (rd_en && (r_state != S_RUN)) begin
        r_rd_data <= r_bins[rd_addr];
      end
    end
  end

  assign rd_data       = r_rd_data;
  assign rd_valid      = r_rd_valid;
  assign busy          = r_busy;
  assign done          = r_done;
  assign total_samples = r_total;
  assign sat_flag      = r_sat;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_pbit_state_histogram.sv
// Directed bench: two instances share stimulus, one bit-reversing with 16-bit bins,
// one straight-through with 4-bit bins so saturation is reachable quickly.
module tb_pbit_state_histogram;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] sample_target = 32'd0;
  logic [4:0]  state_in = 5'd0;
  logic        rd_en = 1'b0;
  logic [4:0]  rd_addr = 5'd0;

  logic [15:0] rd_data_a;
  logic        rd_valid_a, busy_a, done_a, sat_a;
  logic [31:0] total_a;
  logic [1:0]  dbg_a;
  logic [3:0]  rd_data_b;
  logic        rd_valid_b, busy_b, done_b, sat_b;
  logic [31:0] total_b;
  logic [1:0]  dbg_b;

  int n_total = 0;
  int n_bad   = 0;
  int n_cyc;

  pbit_state_histogram #(.NBITS(5), .SAMPLE_DIV(15), .CNT_W(16), .REVERSE(1'b1)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .start(start), .stop(stop), .sample_target(sample_target),
    .state_in(state_in), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .busy(busy_a), .done(done_a), .total_samples(total_a),
    .sat_flag(sat_a), .o_dbg_state(dbg_a)
  );

  pbit_state_histogram #(.NBITS(5), .SAMPLE_DIV(15), .CNT_W(4), .REVERSE(1'b0)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .start(start), .stop(stop), .sample_target(sample_target),
    .state_in(state_in), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .busy(busy_b), .done(done_b), .total_samples(total_b),
    .sat_flag(sat_b), .o_dbg_state(dbg_b)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done_a && n < budget) begin
      step();
      n++;
    end
    if (!done_a) check_eq("timeout_done", 32'd0, 32'd1);
  endtask

  // Back-to-back reads of every bin; expected = val at idx, all_val elsewhere.
  task automatic read_all(input string tag, input int a_idx, input int a_val,
                          input int b_idx, input int b_val, input int all_val);
    for (int i = 0; i < 32; i++) begin
      rd_en   = 1'b1;
      rd_addr = 5'(i);
      step();
      check_eq($sformatf("%s_va%0d", tag, i), 32'(rd_valid_a), 32'd1);
      check_eq($sformatf("%s_da%0d", tag, i), 32'(rd_data_a), (i == a_idx) ? a_val : all_val);
      check_eq($sformatf("%s_vb%0d", tag, i), 32'(rd_valid_b), 32'd1);
      check_eq($sformatf("%s_db%0d", tag, i), 32'(rd_data_b), (i == b_idx) ? b_val : all_val);
    end
    rd_en = 1'b0;
    step();
    check_eq({tag, "_vdrop"}, 32'(rd_valid_a), 32'd0);
  endtask

  initial begin
    // reset block
    RST_N = 1'b0;
    repeat (3) step();
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_done", 32'(done_a), 32'd0);
    check_eq("rst_total", total_a, 32'd0);
    check_eq("rst_sat", 32'(sat_a), 32'd0);
    check_eq("rst_rdv", 32'(rd_valid_a), 32'd0);
    check_eq("rst_rdd", 32'(rd_data_a), 32'd0);
    RST_N = 1'b1;
    step();

    // 1: constant 00001, target 10; reversed -> bin 16, straight -> bin 1
    state_in      = 5'b00001;
    sample_target = 32'd10;
    pulse_start();
    check_eq("s1_busy", 32'(busy_a), 32'd1);
    repeat (15) step();
    check_eq("s1_pre_commit", total_a, 32'd0);
    step();
    check_eq("s1_first_commit", total_a, 32'd1);
    wait_done(300, n_cyc);
    check_eq("s1_done_cycle", 32'(16 + n_cyc), 32'd151);
    check_eq("s1_done_a", 32'(done_a), 32'd1);
    check_eq("s1_busy_a", 32'(busy_a), 32'd0);
    check_eq("s1_done_b", 32'(done_b), 32'd1);
    check_eq("s1_total_a", total_a, 32'd10);
    check_eq("s1_total_b", total_b, 32'd10);
    check_eq("s1_sat_b", 32'(sat_b), 32'd0);
    read_all("s1", 16, 10, 1, 10, 0);

    // 2: step through all 32 states twice, target 64 -> every bin 2
    state_in      = 5'd0;
    sample_target = 32'd64;
    pulse_start();
    for (int k = 0; k < 64; k++) begin
      repeat (15) step();
      state_in = 5'(k + 1);
    end
    wait_done(50, n_cyc);
    check_eq("s2_total_a", total_a, 32'd64);
    check_eq("s2_total_b", total_b, 32'd64);
    check_eq("s2_sat_a", 32'(sat_a), 32'd0);
    check_eq("s2_sat_b", 32'(sat_b), 32'd0);
    read_all("s2", -1, 0, -1, 0, 2);

    // 3/4/5: free-run on constant 3, read attempt in RUN, stop 1 cycle after tick 20
    state_in      = 5'd3;
    sample_target = 32'd0;
    pulse_start();
    rd_en   = 1'b1;
    rd_addr = 5'd0;
    step();
    rd_en = 1'b0;
    check_eq("s5_run_rdv_a", 32'(rd_valid_a), 32'd0);
    check_eq("s5_run_rdv_b", 32'(rd_valid_b), 32'd0);
    check_eq("s5_run_rdd_hold", 32'(rd_data_a), 32'd2);
    repeat (299) step();
    pulse_stop();
    check_eq("s3_done_a", 32'(done_a), 32'd1);
    check_eq("s3_total_a", total_a, 32'd20);
    repeat (40) step();
    check_eq("s4_no_more_ticks", total_a, 32'd20);
    check_eq("s3_total_b", total_b, 32'd20);
    check_eq("s3_sat_a", 32'(sat_a), 32'd0);
    check_eq("s3_sat_b", 32'(sat_b), 32'd1);
    check_eq("s3_done_b", 32'(done_b), 32'd1);
    read_all("s3", 24, 20, 3, 15, 0);

    // 4: start and stop together from DONE -> RUN, cleared
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check_eq("s4_both_busy", 32'(busy_a), 32'd1);
    check_eq("s4_both_done", 32'(done_a), 32'd0);
    check_eq("s4_both_total", total_a, 32'd0);
    check_eq("s4_both_sat_b", 32'(sat_b), 32'd0);
    pulse_stop();
    check_eq("s4_stop_done", 32'(done_a), 32'd1);
    read_all("s4", -1, 0, -1, 0, 0);

    // 6: async reset mid-RUN, then a fresh run
    state_in = 5'd5;
    pulse_start();
    repeat (20) step();
    check_eq("s6_pre_total", total_a, 32'd1);
    RST_N = 1'b0;
    #1;
    check_eq("s6_rst_busy", 32'(busy_a), 32'd0);
    check_eq("s6_rst_total", total_a, 32'd0);
    step();
    RST_N = 1'b1;
    step();
    check_eq("s6_idle_done", 32'(done_a), 32'd0);
    check_eq("s6_idle_busy", 32'(busy_a), 32'd0);
    read_all("s6z", -1, 0, -1, 0, 0);
    sample_target = 32'd2;
    pulse_start();
    repeat (15) step();
    check_eq("s6_pre_commit", total_a, 32'd0);
    step();
    check_eq("s6_first_commit", total_a, 32'd1);
    wait_done(100, n_cyc);
    check_eq("s6_done_cycle", 32'(16 + n_cyc), 32'd31);
    check_eq("s6_total_b", total_b, 32'd2);
    read_all("s6", 20, 2, 5, 2, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
